// File: rtl/weather_pkg.sv
// Shared weather definitions: visibility codes, invalid-temperature marker and range thresholds.
package weather_pkg;

  localparam logic [1:0] VIS_CLEAR   = 2'b00;
  localparam logic [1:0] VIS_REDUCED = 2'b01;
  localparam logic [1:0] VIS_POOR    = 2'b10;
  localparam logic [1:0] VIS_ZERO    = 2'b11;

  localparam logic [7:0] TEMP_INVALID = 8'h80;

  // Visibility range thresholds, units of 100 m
  localparam logic [7:0] VIS_TH_CLEAR   = 8'd50;
  localparam logic [7:0] VIS_TH_REDUCED = 8'd20;
  localparam logic [7:0] VIS_TH_POOR    = 8'd10;

  function automatic logic [1:0] vis_class(input logic [7:0] range);
    if (range >= VIS_TH_CLEAR)        return VIS_CLEAR;
    else if (range >= VIS_TH_REDUCED) return VIS_REDUCED;
    else if (range >= VIS_TH_POOR)    return VIS_POOR;
    else                              return VIS_ZERO;
  endfunction

endpackage

// File: rtl/wind_moving_avg.sv
// Moving average of the last 2^WIN_LOG2 wind samples; result registered on the accepting edge.
// No backpressure: a sample is taken on every cycle with smp_vld_i high, otherwise all state holds.
module wind_moving_avg #(
  parameter int WIN_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       smp_vld_i,
  input  logic [5:0] raw_wind_i,
  output logic [5:0] wind_o,
  output logic       data_valid_o
);

  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = 6 + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FULL = {1'b1, {WIN_LOG2{1'b0}}};

  // Newest sample in the low slot, oldest in the high slot
  logic [N*6-1:0]    win_q, win_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [WIN_LOG2:0] fill_q, fill_d;
  logic [5:0]        wind_q, wind_d;
  logic              dv_q, dv_d;
  logic [SW-1:0]     sum_shift;

  always_comb begin
    win_d     = win_q;
    sum_d     = sum_q;
    fill_d    = fill_q;
    wind_d    = wind_q;
    dv_d      = dv_q;
    sum_shift = '0;
    if (smp_vld_i) begin
      sum_d     = sum_q + SW'(raw_wind_i) - SW'(win_q[N*6-1 -: 6]);
      win_d     = {win_q[(N-1)*6-1:0], raw_wind_i};
      sum_shift = sum_d >> WIN_LOG2;
      wind_d    = sum_shift[5:0];
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
      dv_d      = dv_q | (fill_d == FULL);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      wind_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
      wind_q <= wind_d;
      dv_q   <= dv_d;
    end
  end

  assign wind_o       = wind_q;
  assign data_valid_o = dv_q;

endmodule

// File: rtl/weather_sensor_conditioner.sv
// Conditions raw weather samples into held wind/temperature/visibility/storm levels, updated on the accepting edge.
// No backpressure: every sample_valid strobe is consumed; update pulses for the cycle after it.
module weather_sensor_conditioner
  import weather_pkg::*;
#(
  parameter int WIN_LOG2      = 2,
  parameter int STRIKE_WEIGHT = 4,
  parameter int STORM_ON      = 8,
  parameter int SCORE_MAX     = 15,
  parameter int FAULT_LIMIT   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic [5:0] raw_wind,
  input  logic [7:0] raw_temp,
  input  logic [7:0] raw_vis,
  input  logic       raw_lightning,
  output logic [5:0] wind,
  output logic [7:0] temperature,
  output logic [1:0] visibility,
  output logic       thunderstorm,
  output logic       sensor_fault,
  output logic       data_valid,
  output logic       update
);

  localparam logic [4:0] WEIGHT5 = 5'(STRIKE_WEIGHT);
  localparam logic [4:0] SMAX5   = 5'(SCORE_MAX);
  localparam logic [3:0] SON4    = 4'(STORM_ON);
  localparam logic [1:0] FLIM2   = 2'(FAULT_LIMIT);

  logic [7:0] temp_q, temp_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       fault_q, fault_d;
  logic [1:0] vis_q, vis_d;
  logic [1:0] cand_q, cand_d;
  logic       cand_vld_q, cand_vld_d;
  logic [3:0] score_q, score_d;
  logic       storm_q, storm_d;
  logic       upd_q;
  logic [1:0] vis_new;
  logic [4:0] score_up;

  wind_moving_avg #(.WIN_LOG2(WIN_LOG2)) u_wind (
    .CLK          (CLK),
    .RST          (RST),
    .smp_vld_i    (sample_valid),
    .raw_wind_i   (raw_wind),
    .wind_o       (wind),
    .data_valid_o (data_valid)
  );

  always_comb begin
    temp_d     = temp_q;
    fcnt_d     = fcnt_q;
    fault_d    = fault_q;
    vis_d      = vis_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    score_d    = score_q;
    storm_d    = storm_q;
    vis_new    = vis_class(raw_vis);
    score_up   = {1'b0, score_q} + WEIGHT5;
    if (sample_valid) begin
      if (raw_temp != TEMP_INVALID) begin
        temp_d  = raw_temp;
        fcnt_d  = '0;
        fault_d = 1'b0;
      end else begin
        if (fcnt_q != FLIM2) fcnt_d = fcnt_q + 2'd1;
        if (fcnt_d == FLIM2) fault_d = 1'b1;
      end

      // A new class must be seen twice in a row before the output follows it
      if (vis_new == vis_q) begin
        cand_vld_d = 1'b0;
      end else if (cand_vld_q && cand_q == vis_new) begin
        vis_d      = vis_new;
        cand_vld_d = 1'b0;
      end else begin
        cand_d     = vis_new;
        cand_vld_d = 1'b1;
      end

      if (raw_lightning) score_d = (score_up > SMAX5) ? SMAX5[3:0] : score_up[3:0];
      else if (score_q != 4'd0) score_d = score_q - 4'd1;
      if (score_d >= SON4) storm_d = 1'b1;
      else if (score_d == 4'd0) storm_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      temp_q     <= '0;
      fcnt_q     <= '0;
      fault_q    <= 1'b0;
      vis_q      <= VIS_CLEAR;
      cand_q     <= VIS_CLEAR;
      cand_vld_q <= 1'b0;
      score_q    <= '0;
      storm_q    <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      temp_q     <= temp_d;
      fcnt_q     <= fcnt_d;
      fault_q    <= fault_d;
      vis_q      <= vis_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      score_q    <= score_d;
      storm_q    <= storm_d;
      upd_q      <= sample_valid;
    end
  end

  assign temperature  = temp_q;
  assign visibility   = vis_q;
  assign thunderstorm = storm_q;
  assign sensor_fault = fault_q;
  assign update       = upd_q;

endmodule

// File: tb/tb_weather_sensor_conditioner.sv
// Directed and randomized checks of the weather conditioner against a sample-level reference model.
module tb_weather_sensor_conditioner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       sample_valid;
  logic [5:0] raw_wind;
  logic [7:0] raw_temp;
  logic [7:0] raw_vis;
  logic       raw_lightning;
  logic [5:0] wind;
  logic [7:0] temperature;
  logic [1:0] visibility;
  logic       thunderstorm;
  logic       sensor_fault;
  logic       data_valid;
  logic       update;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int         m_win[$];
  int         m_count;
  logic [7:0] m_temp;
  int         m_bad;
  bit         m_fault;
  int         m_vis;
  int         m_cand;
  int         m_score;
  bit         m_storm;

  always #5 CLK = ~CLK;

  weather_sensor_conditioner dut (
    .CLK           (CLK),
    .RST           (RST),
    .sample_valid  (sample_valid),
    .raw_wind      (raw_wind),
    .raw_temp      (raw_temp),
    .raw_vis       (raw_vis),
    .raw_lightning (raw_lightning),
    .wind          (wind),
    .temperature   (temperature),
    .visibility    (visibility),
    .thunderstorm  (thunderstorm),
    .sensor_fault  (sensor_fault),
    .data_valid    (data_valid),
    .update        (update)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    m_count = 0;
    m_temp  = 8'h00;
    m_bad   = 0;
    m_fault = 0;
    m_vis   = 0;
    m_cand  = -1;
    m_score = 0;
    m_storm = 0;
  endtask

  function automatic int classify(input int r);
    if (r >= 50) return 0;
    if (r >= 20) return 1;
    if (r >= 10) return 2;
    return 3;
  endfunction

  task automatic model_step(input int w, input logic [7:0] t, input int v, input bit l);
    int sum;
    int c;
    m_win.push_front(w);
    if (m_win.size() > 4) void'(m_win.pop_back());
    if (m_count < 4) m_count++;
    sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    if (t != 8'h80) begin
      m_temp  = t;
      m_bad   = 0;
      m_fault = 0;
    end else begin
      if (m_bad < 3) m_bad++;
      if (m_bad == 3) m_fault = 1;
    end
    c = classify(v);
    if (c == m_vis) m_cand = -1;
    else if (c == m_cand) begin m_vis = c; m_cand = -1; end
    else m_cand = c;
    if (l) m_score = (m_score + 4 > 15) ? 15 : m_score + 4;
    else if (m_score > 0) m_score--;
    if (m_score >= 8) m_storm = 1;
    else if (m_score == 0) m_storm = 0;
    m_win.push_back(sum);  // stash the current sum at the back temporarily
    void'(m_win.pop_back());
  endtask

  function automatic int model_wind();
    int sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    return sum / 4;
  endfunction

  task automatic check_all(input bit exp_upd);
    chk("wind",         32'(wind),         32'(model_wind()));
    chk("temperature",  32'(temperature),  32'(m_temp));
    chk("visibility",   32'(visibility),   32'(m_vis));
    chk("thunderstorm", 32'(thunderstorm), 32'(m_storm));
    chk("sensor_fault", 32'(sensor_fault), 32'(m_fault));
    chk("data_valid",   32'(data_valid),   32'(m_count == 4));
    chk("update",       32'(update),       32'(exp_upd));
  endtask

  task automatic smp(input logic [5:0] w, input logic [7:0] t, input logic [7:0] v, input bit l);
    @(negedge CLK);
    raw_wind      = w;
    raw_temp      = t;
    raw_vis       = v;
    raw_lightning = l;
    sample_valid  = 1'b1;
    @(posedge CLK);
    #1;
    sample_valid = 1'b0;
    model_step(int'(w), t, int'(v), l);
    check_all(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check_all(1'b0);
    end
  endtask

  initial begin
    RST           = 1'b1;
    sample_valid  = 1'b0;
    raw_wind      = '0;
    raw_temp      = '0;
    raw_vis       = '0;
    raw_lightning = 1'b0;
    model_reset();
    #1;
    check_all(1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(1);

    // Wind window fill
    smp(6'd10, 8'd25, 8'd60, 1'b0);
    smp(6'd12, 8'd25, 8'd60, 1'b0);
    chk("t1_wind_partial", 32'(wind), 32'd5);
    chk("t1_dv_partial",   32'(data_valid), 32'd0);
    smp(6'd14, 8'd25, 8'd60, 1'b0);
    smp(6'd16, 8'd25, 8'd60, 1'b0);
    chk("t1_wind_full", 32'(wind), 32'd13);
    chk("t1_dv_full",   32'(data_valid), 32'd1);
    idle(2);

    // Wind at full scale, then draining
    repeat (4) smp(6'd63, 8'd25, 8'd60, 1'b0);
    chk("t2_wind_max", 32'(wind), 32'd63);
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    chk("t2_drain1", 32'(wind), 32'd47);
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    chk("t2_drain2", 32'(wind), 32'd31);
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    chk("t2_drain3", 32'(wind), 32'd15);
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    chk("t2_drain4", 32'(wind), 32'd0);

    // Visibility debounce
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    smp(6'd0, 8'd25, 8'd15, 1'b0);
    smp(6'd0, 8'd25, 8'd60, 1'b0);
    chk("t3_vis_glitch", 32'(visibility), 32'd0);
    smp(6'd0, 8'd25, 8'd15, 1'b0);
    chk("t3_vis_first", 32'(visibility), 32'd0);
    smp(6'd0, 8'd25, 8'd15, 1'b0);
    chk("t3_vis_poor", 32'(visibility), 32'd2);
    smp(6'd0, 8'd25, 8'd5, 1'b0);
    smp(6'd0, 8'd25, 8'd25, 1'b0);
    chk("t3_vis_hold", 32'(visibility), 32'd2);

    // Storm hysteresis
    smp(6'd0, 8'd25, 8'd15, 1'b1);
    chk("t4_storm_one", 32'(thunderstorm), 32'd0);
    smp(6'd0, 8'd25, 8'd15, 1'b1);
    chk("t4_storm_on", 32'(thunderstorm), 32'd1);
    repeat (7) smp(6'd0, 8'd25, 8'd15, 1'b0);
    chk("t4_storm_hold", 32'(thunderstorm), 32'd1);
    smp(6'd0, 8'd25, 8'd15, 1'b0);
    chk("t4_storm_off", 32'(thunderstorm), 32'd0);

    // Temperature validity and fault
    smp(6'd0, 8'd25, 8'd15, 1'b0);
    smp(6'd0, 8'h80, 8'd15, 1'b0);
    smp(6'd0, 8'h80, 8'd15, 1'b0);
    chk("t5_fault_early", 32'(sensor_fault), 32'd0);
    smp(6'd0, 8'h80, 8'd15, 1'b0);
    chk("t5_fault_set", 32'(sensor_fault), 32'd1);
    chk("t5_temp_hold", 32'(temperature), 32'd25);
    smp(6'd0, 8'hD8, 8'd15, 1'b0);
    chk("t5_temp_neg", 32'(temperature), 32'hD8);
    chk("t5_fault_clr", 32'(sensor_fault), 32'd0);

    // Asynchronous reset mid-window
    smp(6'd20, 8'd10, 8'd60, 1'b1);
    smp(6'd30, 8'd10, 8'd60, 1'b1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check_all(1'b0);
    #2;
    RST = 1'b0;
    idle(1);
    smp(6'd8, 8'd5, 8'd60, 1'b0);
    smp(6'd8, 8'd5, 8'd60, 1'b0);
    smp(6'd8, 8'd5, 8'd60, 1'b0);
    chk("t6_dv_low", 32'(data_valid), 32'd0);
    smp(6'd8, 8'd5, 8'd60, 1'b0);
    chk("t6_dv_high", 32'(data_valid), 32'd1);
    chk("t6_storm_low", 32'(thunderstorm), 32'd0);

    // Randomized samples with idle gaps
    for (int i = 0; i < 400; i++) begin
      logic [5:0] w;
      logic [7:0] t;
      logic [7:0] v;
      bit         l;
      w = 6'($urandom_range(0, 63));
      t = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      v = 8'($urandom_range(0, 70));
      l = ($urandom_range(0, 2) == 0);
      smp(w, t, v, l);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
